// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnLs = 1'b1
  } owner_e;

  localparam int unsigned StarveCntW = 4;
  localparam logic [StarveCntW-1:0] StarveCntMax = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned MaskW = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [MaskW-1:0]  ls_wmask_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [MaskW-1:0]  mem_wmask_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              err_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output err_o
  );

  // Requester and memory side.
  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  err_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Priority select between fetch and load/store, with a starvation counter
// that hands fetch the win after STARVE_MAX consecutive losses.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  logic   capture_en_i,
  output owner_e winner_o,
  output logic   grant_valid_o
);

  logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
  logic                  if_starved;

  always_comb begin
    if_starved    = starve_cnt_q >= StarveCntW'(STARVE_MAX);
    winner_o      = OwnIf;
    if (ls_req_i && !(if_req_i && if_starved)) begin
      winner_o = OwnLs;
    end
    grant_valid_o = capture_en_i && (if_req_i || ls_req_i);

    starve_cnt_d = starve_cnt_q;
    if (grant_valid_o) begin
      if (winner_o == OwnIf) begin
        starve_cnt_d = '0;
      end else if (if_req_i && (starve_cnt_q != StarveCntMax)) begin
        starve_cnt_d = starve_cnt_q + StarveCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between fetch and
// load/store with a single outstanding transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned MaskW = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
  logic              err_q, err_d;

  logic   resp_fire;
  logic   capture_en;
  logic   grant_valid;
  owner_e winner;

  assign resp_fire  = (state_q == StResp) && bus.mem_rvalid_i;
  // Gated by reset so no grant can pulse while the state is held in idle.
  assign capture_en = reset && ((state_q == StIdle) || resp_fire);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_i        (clock),
    .rst_ni       (reset),
    .if_req_i     (bus.if_req_i),
    .ls_req_i     (bus.ls_req_i),
    .capture_en_i (capture_en),
    .winner_o     (winner),
    .grant_valid_o(grant_valid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StReq;
      StReq:   if (bus.mem_gnt_i) state_d = StResp;
      StResp:  if (bus.mem_rvalid_i) state_d = grant_valid ? StReq : StIdle;
      default: state_d = StIdle;
    endcase

    if (grant_valid) begin
      owner_d = winner;
      if (winner == OwnLs) begin
        addr_d  = bus.ls_addr_i;
        we_d    = bus.ls_we_i;
        wdata_d = bus.ls_wdata_i;
        wmask_d = bus.ls_wmask_i;
      end else begin
        addr_d  = bus.if_addr_i;
        we_d    = 1'b0;
        wdata_d = '0;
        wmask_d = '0;
      end
    end

    // Stray responses/grants are dropped but flagged until the next reset.
    if ((bus.mem_rvalid_i && (state_q != StResp)) || (bus.mem_gnt_i && (state_q != StReq))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      err_q   <= err_d;
    end
  end

  assign bus.if_gnt_o    = grant_valid && (winner == OwnIf);
  assign bus.ls_gnt_o    = grant_valid && (winner == OwnLs);
  assign bus.if_rvalid_o = resp_fire && (owner_q == OwnIf);
  assign bus.ls_rvalid_o = resp_fire && (owner_q == OwnLs);
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = bus.ls_rvalid_o ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = (state_q == StReq);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wmask_o = wmask_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a reactive memory model that has
// programmable grant wait and response latency.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } st_t;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] if_exp_q[$];
  logic [63:0] ls_exp_q[$];
  st_t         st_q[$];
  int          gnt_log[$];
  int          if_gnt_cyc = -1;
  int          ls_rv_cyc = -2;
  logic [63:0] mem_arr[logic [63:0]];

  int          gnt_wait = 0;
  int          rsp_lat = 1;
  int          wait_cnt = 0;
  int          rsp_cnt = 0;
  int          req_cycles = 0;
  bit          rsp_pend = 0;
  bit          inject_rv = 0;
  bit          inject_gnt = 0;
  logic [63:0] rsp_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dflt_data(input logic [63:0] addr);
    if (addr == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {addr[31:0], ~addr[31:0]};
  endfunction

  function automatic logic [63:0] rd_model(input logic [63:0] addr);
    if (mem_arr.exists(addr)) return mem_arr[addr];
    return dflt_data(addr);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model: decides gnt/rvalid for each cycle just after the clock edge.
  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rsp_data;
          rsp_pend         = 0;
        end else begin
          rsp_cnt--;
        end
      end
      if (inject_rv) bus.mem_rvalid_i = 1'b1;
      if (inject_gnt) bus.mem_gnt_i = 1'b1;
      if (bus.mem_req_o) begin
        req_cycles++;
        if (bus.mem_we_o) begin
          if (st_q.size() == 0) begin
            check_eq("store_unexpected", 64'(bus.mem_we_o), 0);
          end else begin
            check_eq("st_addr", bus.mem_addr_o, st_q[0].addr);
            check_eq("st_wdata", bus.mem_wdata_o, st_q[0].data);
            check_eq("st_wmask", 64'(bus.mem_wmask_o), 64'(st_q[0].mask));
          end
        end
        if (wait_cnt < gnt_wait) begin
          wait_cnt++;
        end else begin
          wait_cnt      = 0;
          bus.mem_gnt_i = 1'b1;
          rsp_pend      = 1;
          rsp_cnt       = rsp_lat - 1;
          if (bus.mem_we_o) begin
            mem_arr[bus.mem_addr_o] = merge(rd_model(bus.mem_addr_o), bus.mem_wdata_o,
                                            bus.mem_wmask_o);
            rsp_data = '0;
            if (st_q.size() > 0) void'(st_q.pop_front());
          end else begin
            check_eq("rd_wmask", 64'(bus.mem_wmask_o), 0);
            rsp_data = rd_model(bus.mem_addr_o);
          end
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.if_gnt_o || bus.ls_gnt_o) begin
        check_eq("gnt_onehot", 64'(bus.if_gnt_o & bus.ls_gnt_o), 0);
        if (bus.if_gnt_o) begin
          gnt_log.push_back(0);
          if_gnt_cyc = cyc;
        end else begin
          gnt_log.push_back(1);
        end
      end
      if (bus.if_rvalid_o) begin
        if (if_exp_q.size() == 0) check_eq("if_rvalid_unexpected", 64'(bus.if_rvalid_o), 0);
        else check_eq("if_rdata", bus.if_rdata_o, if_exp_q.pop_front());
        check_eq("ls_rvalid_on_if_rsp", 64'(bus.ls_rvalid_o), 0);
        check_eq("ls_rdata_on_if_rsp", bus.ls_rdata_o, 0);
      end else begin
        check_eq("if_rdata_idle", bus.if_rdata_o, 0);
      end
      if (bus.ls_rvalid_o) begin
        ls_rv_cyc = cyc;
        if (ls_exp_q.size() == 0) check_eq("ls_rvalid_unexpected", 64'(bus.ls_rvalid_o), 0);
        else check_eq("ls_rdata", bus.ls_rdata_o, ls_exp_q.pop_front());
        check_eq("if_rdata_on_ls_rsp", bus.if_rdata_o, 0);
      end else begin
        check_eq("ls_rdata_idle", bus.ls_rdata_o, 0);
      end
    end
  end

  task automatic if_fetch(input logic [63:0] addr);
    bit got = 0;
    if_exp_q.push_back(rd_model(addr));
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = bus.if_gnt_o;
    end
    if (!got) check_eq("if_gnt_timeout", 64'(bus.if_gnt_o), 1);
    @(posedge clock);
    #1;
    bus.if_req_i = 1'b0;
  endtask

  task automatic ls_access(input bit we, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [7:0] m, input logic [63:0] exp_rd);
    bit got = 0;
    if (we) st_q.push_back('{addr: addr, data: wd, mask: m});
    ls_exp_q.push_back(exp_rd);
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = we;
    bus.ls_addr_i  = addr;
    bus.ls_wdata_i = wd;
    bus.ls_wmask_i = m;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = bus.ls_gnt_o;
    end
    if (!got) check_eq("ls_gnt_timeout", 64'(bus.ls_gnt_o), 1);
    @(posedge clock);
    #1;
    bus.ls_req_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      done = (if_exp_q.size() == 0) && (ls_exp_q.size() == 0) && !rsp_pend && !bus.mem_req_o;
    end
    if (!done) check_eq("drain_timeout", 64'(done), 1);
  endtask

  initial begin
    int exp_order[6] = '{1, 1, 1, 1, 0, 1};
    logic [63:0] st_addr = 64'h8000_1000;

    reset          = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 64'h8000_0000;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    bus.ls_wmask_i = '0;

    // Reset state, with a fetch request held that must not be granted.
    repeat (2) @(negedge clock);
    check_eq("rst_if_gnt", 64'(bus.if_gnt_o), 0);
    check_eq("rst_mem_req", 64'(bus.mem_req_o), 0);
    check_eq("rst_mem_addr", bus.mem_addr_o, 0);
    check_eq("rst_err", 64'(bus.err_o), 0);
    check_eq("rst_if_rvalid", 64'(bus.if_rvalid_o), 0);
    bus.if_req_i = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // 1: fetch only, exact cycle timing.
    @(posedge clock);
    #1;
    if_exp_q.push_back(64'h0000_0013_0000_0093);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_0000;
    @(negedge clock);
    check_eq("t1_if_gnt_N", 64'(bus.if_gnt_o), 1);
    check_eq("t1_mem_req_N", 64'(bus.mem_req_o), 0);
    @(posedge clock);
    #1;
    bus.if_req_i = 1'b0;
    @(negedge clock);
    check_eq("t1_mem_req_N1", 64'(bus.mem_req_o), 1);
    check_eq("t1_mem_addr", bus.mem_addr_o, 64'h8000_0000);
    check_eq("t1_mem_we", 64'(bus.mem_we_o), 0);
    check_eq("t1_if_gnt_N1", 64'(bus.if_gnt_o), 0);
    @(negedge clock);
    check_eq("t1_if_rvalid_N2", 64'(bus.if_rvalid_o), 1);
    check_eq("t1_if_rdata_N2", bus.if_rdata_o, 64'h0000_0013_0000_0093);
    check_eq("t1_ls_rvalid", 64'(bus.ls_rvalid_o), 0);
    @(negedge clock);
    check_eq("t1_mem_req_after", 64'(bus.mem_req_o), 0);
    wait_drain();

    // 2: collision with starve_cnt = 0.
    gnt_log.delete();
    if_gnt_cyc = -1;
    ls_rv_cyc  = -2;
    @(posedge clock);
    #1;
    fork
      if_fetch(64'h8000_0100);
      ls_access(1'b0, 64'h8000_0200, '0, '0, rd_model(64'h8000_0200));
      begin
        @(negedge clock);
        @(posedge clock);
        #1;
        check_eq("t2_starve_cnt", 64'(dut.u_pick.starve_cnt_q), 1);
      end
    join
    wait_drain();
    check_eq("t2_n_gnts", 64'(gnt_log.size()), 2);
    check_eq("t2_first_ls", 64'(gnt_log[0]), 1);
    check_eq("t2_second_if", 64'(gnt_log[1]), 0);
    check_eq("t2_b2b_capture", 64'(if_gnt_cyc), 64'(ls_rv_cyc));

    // 3: starvation, LS streaming while IF holds its request.
    gnt_log.delete();
    @(posedge clock);
    #1;
    fork
      if_fetch(64'h8000_0400);
      for (int k = 0; k < 5; k++) begin
        ls_access(1'b0, 64'h8000_0800 + 64'(k * 8), '0, '0, rd_model(64'h8000_0800 + 64'(k * 8)));
      end
    join
    wait_drain();
    check_eq("t3_n_gnts", 64'(gnt_log.size()), 6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("t3_order%0d", k), 64'(gnt_log[k]),
                                         64'(exp_order[k]));
    check_eq("t3_starve_cleared", 64'(dut.u_pick.starve_cnt_q), 0);

    // 4: store with 3 grant-wait cycles, then read it back.
    gnt_wait   = 3;
    rsp_lat    = 2;
    req_cycles = 0;
    @(posedge clock);
    #1;
    ls_access(1'b1, st_addr, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h0);
    wait_drain();
    check_eq("t4_req_cycles", 64'(req_cycles), 4);
    check_eq("t4_store_consumed", 64'(st_q.size()), 0);
    gnt_wait = 0;
    rsp_lat  = 1;
    @(posedge clock);
    #1;
    ls_access(1'b0, st_addr, '0, '0, 64'h8000_1000_DEAD_BEEF);
    wait_drain();
    check_eq("t4_err_clean", 64'(bus.err_o), 0);

    // 5: stray response in idle.
    inject_rv = 1;
    @(negedge clock);
    inject_rv = 0;
    check_eq("t5_no_if_rvalid", 64'(bus.if_rvalid_o), 0);
    check_eq("t5_no_ls_rvalid", 64'(bus.ls_rvalid_o), 0);
    @(negedge clock);
    check_eq("t5_err_set", 64'(bus.err_o), 1);
    repeat (4) @(negedge clock);
    check_eq("t5_err_sticky", 64'(bus.err_o), 1);

    // 6: reset while waiting for a response; the late response flags an error.
    rsp_lat = 8;
    @(posedge clock);
    #1;
    if_fetch(64'h8000_0300);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_mem_req", 64'(bus.mem_req_o), 0);
    check_eq("t6_rst_mem_addr", bus.mem_addr_o, 0);
    check_eq("t6_rst_if_rvalid", 64'(bus.if_rvalid_o), 0);
    check_eq("t6_rst_err", 64'(bus.err_o), 0);
    check_eq("t6_rst_state", 64'(dut.state_q), 64'(StIdle));
    if_exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 50 && rsp_pend; i++) @(negedge clock);
    @(negedge clock);
    check_eq("t6_late_rvalid_err", 64'(bus.err_o), 1);
    rsp_lat = 1;
    @(posedge clock);
    #1;
    if_fetch(64'h8000_0000);
    wait_drain();

    // 7: grant from memory while no request is outstanding.
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t7_err_cleared", 64'(bus.err_o), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    inject_gnt = 1;
    @(negedge clock);
    inject_gnt = 0;
    @(negedge clock);
    check_eq("t7_gnt_err", 64'(bus.err_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between instruction fetch and load/store.
- Sits between the fetch and memory stages and the memory model; replaces the dedicated fetch-read path on the memory.
- Allows one outstanding transaction at a time.
- Load/store has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (byte mask width = DATA_W/8)
STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins (range 1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req_i  in  1  fetch request; held with address until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  one-cycle pulse: fetch request captured
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DATA_W  fetch read data
ls_req_i  in  1  load/store request; held with payload until ls_gnt_o
ls_we_i  in  1  1 = store
ls_addr_i  in  ADDR_W  load/store address
ls_wdata_i  in  DATA_W  store data
ls_wmask_i  in  DATA_W/8  store byte enables
ls_gnt_o  out  1  one-cycle pulse: load/store request captured
ls_rvalid_o  out  1  load data valid / store acknowledge
ls_rdata_o  out  DATA_W  load data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_wmask_o  out  DATA_W/8  memory byte enables
mem_gnt_i  in  1  memory accepted mem_req_o this cycle
mem_rvalid_i  in  1  response valid; for writes this is the ack
mem_rdata_i  in  DATA_W  response data
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, async): state IDLE, owner=IF, starve_cnt=0, err_o=0, and all mem_* registers 0. Every *_gnt_o and *_rvalid_o is 0. Both rdata outputs are 0.
- FSM states:
  - IDLE: capture one request if any.
  - REQ: mem_req_o=1, wait for mem_gnt_i.
  - RESP: wait for mem_rvalid_i.
- Capture happens in IDLE, or in RESP on the cycle mem_rvalid_i=1. This allows back-to-back transactions with zero idle cycles.
- Arbitration at capture:
  - Only one requester: it wins.
  - Both requesting: LS wins unless starve_cnt >= STARVE_MAX, in which case IF wins.
- Capture effects:
  - Registers owner, addr, we, wdata and wmask into the mem_* registers.
  - Pulses the winner's gnt_o combinationally in the same cycle.
  - Next state is REQ.
- IF captures always drive we=0 and wmask=0.
- starve_cnt:
  - +1 (saturating at 15) when IF requests and LS wins.
  - Cleared to 0 when IF wins.
  - Otherwise unchanged.
- REQ: mem_req_o and payload are held stable until mem_gnt_i=1, then next state is RESP. mem_req_o deasserts the following cycle.
- RESP:
  - mem_rvalid_i is routed combinationally to the owner's rvalid_o, with rdata = mem_rdata_i in the same cycle.
  - The non-owner's rvalid_o stays 0 and its rdata_o is 0.
  - After rvalid: next state is REQ if a new capture occurred, otherwise IDLE.
- Minimum latency: capture in cycle N, mem_req_o in N+1, gnt in N+1, rvalid in N+2 at the earliest.
- Protocol errors:
  - mem_rvalid_i=1 in IDLE or REQ sets err_o. The response is dropped and no rvalid_o is produced.
  - mem_gnt_i=1 while mem_req_o=0 sets err_o.
  - err_o clears only on reset.
- A requester dropping req before gnt is legal: it is simply not arbitrated.
- Reset asserted mid-transaction: immediate return to IDLE and any in-flight response is lost. After reset deasserts, a late mem_rvalid_i sets err_o.

Decomposition:
- Shared package: state enum (IDLE/REQ/RESP), owner encoding (OWN_IF=0, OWN_LS=1), counter width constant (4 bits).
- Sub-module mem_arb_pick: combinational priority select plus the starve_cnt register. Inputs if_req, ls_req, capture_en; outputs winner and grant_valid.

Test Plan:
1. Fetch only:
   - Stimulus: if_req=1, addr=0x80000000. Memory grants immediately and returns rdata=0x00000013_00000093 after 1 cycle.
   - Required: if_gnt_o at N, mem_req_o at N+1, if_rvalid_o and data at N+2, ls_rvalid_o stays 0.
2. Collision:
   - Stimulus: if_req and ls_req (load) both set in the same cycle, starve_cnt=0.
   - Required: ls_gnt_o first and starve_cnt=1. IF is captured on the LS rvalid cycle, back-to-back.
3. Starvation:
   - Stimulus: LS requests continuously while IF is held with STARVE_MAX=4.
   - Required: LS wins 4 times, IF wins the 5th arbitration, then starve_cnt=0.
4. Store:
   - Stimulus: ls_we=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, with 3 gnt-wait cycles.
   - Required: mem_* payload stable for all 4 REQ cycles. ls_rvalid_o is asserted on the ack.
5. Protocol error:
   - Stimulus: pulse mem_rvalid_i in IDLE.
   - Required: err_o=1, no rvalid_o, err_o persists until reset.
6. Reset mid-RESP:
   - Stimulus: drop reset while waiting for rvalid.
   - Required: all outputs 0 asynchronously, state IDLE, a new fetch captured normally after release.
